// File: rtl/div_pkg.sv
// Shared arithmetic-datapath definitions for the divider: FSM state type and
// the default operand widths also used by the shift-add multiplier.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_N_DEFAULT = 8;
    localparam int DIV_M_DEFAULT = 8;

endpackage

// File: rtl/divider_if.sv
// Start/finish handshake bundle for the sequential divider.
// master = requester (drives operands and start), slave = divider.
interface divider_if #(
    parameter int N = 8,
    parameter int M = 8
);
    logic         start;
    logic [N-1:0] a_in;
    logic [M-1:0] b_in;
    logic [N-1:0] quot;
    logic [M-1:0] rem;
    logic         finish;
    logic         div_by_zero;

    modport master (
        output start, a_in, b_in,
        input  quot, rem, finish, div_by_zero
    );

    modport slave (
        input  start, a_in, b_in,
        output quot, rem, finish, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor in M+1 bits, keep the
// difference when it does not go negative and emit the quotient bit.
module div_step #(
    parameter int M = 8
) (
    input  logic [M-1:0] i_rem,
    input  logic         i_bit,
    input  logic [M-1:0] i_divisor,
    output logic [M-1:0] o_rem,
    output logic         o_qbit
);
    logic [M:0] w_shift;
    logic [M:0] w_diff;
    logic       w_ge;

    // Trial subtraction; the result always fits in M bits (it is below the
    // divisor), and with a zero divisor the top bit is shifted out on the
    // next step anyway, so only M bits are carried between steps.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        w_ge    = (w_shift >= {1'b0, i_divisor});
        o_qbit  = w_ge;
        o_rem   = w_ge ? M'(w_diff) : M'(w_shift);
    end
endmodule

// File: rtl/divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock.
// The dividend shift register doubles as the quotient register: dividend bits
// leave at the MSB while quotient bits enter at the LSB.
// Optional build macro: DIVIDER_DBZ_EN -- when defined, a zero divisor is
// detected on the load edge and the result is produced without iterating.
module divider
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT,
    parameter int M = DIV_M_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);

    div_state_t       r_state;
    logic [N-1:0]     r_dvd;
    logic [M-1:0]     r_dvs;
    logic [M-1:0]     r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_finish;
    logic [M-1:0]     w_rem_nxt;
    logic             w_qbit;

    div_step #(.M(M)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[N-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

`ifdef DIVIDER_DBZ_EN
    logic         r_dbz;
    logic [M-1:0] w_a_low;

    assign w_a_low = M'(bus.a_in);

    // Control FSM and datapath registers, with zero-divisor fast path on load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_finish <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_finish <= 1'b0;
                        r_dbz    <= 1'b0;
                        r_dvs    <= bus.b_in;
                        r_cnt    <= CNT_W'(N);
                        if (bus.b_in == '0) begin
                            r_dvd    <= '1;
                            r_rem    <= w_a_low;
                            r_finish <= 1'b1;
                            r_dbz    <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_dvd    <= bus.a_in;
                            r_rem    <= '0;
                            r_state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= N'({r_dvd, w_qbit});
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_finish <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.div_by_zero = r_dbz;
`else
    // Control FSM and datapath registers; a zero divisor iterates normally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_finish <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_dvd    <= bus.a_in;
                        r_dvs    <= bus.b_in;
                        r_rem    <= '0;
                        r_cnt    <= CNT_W'(N);
                        r_finish <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= N'({r_dvd, w_qbit});
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_finish <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.quot   = r_dvd;
    assign bus.rem    = r_rem;
    assign bus.finish = r_finish;
endmodule

// File: tb/tb_divider.sv
// Directed testbench for the 8/8 divider: reset values, several quotient and
// remainder vectors, divide-by-zero, mid-run reset, start ignored while
// running, result hold and restart from DONE.
module tb_divider;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

`ifdef DIVIDER_DBZ_EN
    localparam int DBZ_LAT = 0;
    localparam int DBZ_FLAG = 1;
`else
    localparam int DBZ_LAT = 8;
    localparam int DBZ_FLAG = 0;
`endif

    divider_if #(.N(8), .M(8)) bus ();

    divider #(.N(8), .M(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Pulse start for one edge; returns 1 time unit after the load edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges after the load edge until finish is visible (bounded).
    task automatic wait_finish(output int lat);
        lat = 0;
        while (!bus.finish && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int exp_q, input int exp_r, input int exp_z, input int exp_lat);
        int lat;
        start_op(a, b);
        wait_finish(lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " finish"}, int'(bus.finish), 1);
        check({tag, " quot"}, int'(bus.quot), exp_q);
        check({tag, " rem"}, int'(bus.rem), exp_r);
        check({tag, " dbz"}, int'(bus.div_by_zero), exp_z);
    endtask

    initial begin
        int lat;
        n_chk     = 0;
        n_pass    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset quot", int'(bus.quot), 0);
        check("reset rem", int'(bus.rem), 0);
        check("reset finish", int'(bus.finish), 0);
        check("reset dbz", int'(bus.div_by_zero), 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("200/7", 8'd200, 8'd7, 28, 4, 0, 8);
        run_op("255/1", 8'd255, 8'd1, 255, 0, 0, 8);
        run_op("5/9", 8'd5, 8'd9, 0, 5, 0, 8);
        run_op("255/255", 8'd255, 8'd255, 1, 0, 0, 8);
        run_op("0/3", 8'd0, 8'd3, 0, 0, 0, 8);
        run_op("100/0", 8'd100, 8'd0, 255, 100, DBZ_FLAG, DBZ_LAT);
        run_op("13/13 after dbz", 8'd13, 8'd13, 1, 0, 0, 8);

        // Reset lands on iteration edge 4 of a running divide
        start_op(8'd200, 8'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset finish", int'(bus.finish), 0);
        check("midreset quot", int'(bus.quot), 0);
        check("midreset rem", int'(bus.rem), 0);
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("midreset stays idle", int'(bus.finish), 0);
        run_op("50/6", 8'd50, 8'd6, 8, 2, 0, 8);

        // start toggled with other operands while running must be ignored
        start_op(8'd200, 8'd7);
        lat = 0;
        while (!bus.finish && lat < 40) begin
            if (lat == 2) begin
                bus.start = 1'b1;
                bus.a_in  = 8'd1;
                bus.b_in  = 8'd1;
            end
            if (lat == 5)
                bus.start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        check("ignore latency", lat, 8);
        check("ignore quot", int'(bus.quot), 28);
        check("ignore rem", int'(bus.rem), 4);

        // Result holds in DONE while start stays low
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("hold finish", int'(bus.finish), 1);
        check("hold quot", int'(bus.quot), 28);
        check("hold rem", int'(bus.rem), 4);

        // Restart from DONE: finish drops on the load edge
        start_op(8'd17, 8'd5);
        check("restart finish drop", int'(bus.finish), 0);
        wait_finish(lat);
        check("restart latency", lat, 8);
        check("restart quot", int'(bus.quot), 3);
        check("restart rem", int'(bus.rem), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
